// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: shared state encoding and reset PC for the PC sequencer slice
package pc_sequencer_pkg;
    localparam int PCS_STATE_BIT = 2;
    typedef enum logic [PCS_STATE_BIT-1:0] {
        PCS_BOOT = 2'd0,
        PCS_RUN  = 2'd1,
        PCS_HALT = 2'd2
    } pcs_state_e;
    localparam logic [31:0] PCS_RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: decoder/where-to-go inputs and fetch/debug outputs of the PC sequencer
interface pc_sequencer_if #(parameter int CNT_W = 32);
    logic [31:0]      pc_new;
    logic             branched;
    logic             is_jump;
    logic [31:0]      pc_4;
    logic             stall;
    logic             halt_req;
    logic             resume;
    logic [31:0]      pc;
    logic             fetch_valid;
    logic             flush;
    logic             halted;
    logic [CNT_W-1:0] retired_cnt;
    logic [CNT_W-1:0] taken_cnt;
    logic [CNT_W-1:0] jump_cnt;
    modport master (
        input  pc_new, branched, is_jump, pc_4, stall, halt_req, resume,
        output pc, fetch_valid, flush, halted, retired_cnt, taken_cnt, jump_cnt
    );
    modport slave (
        output pc_new, branched, is_jump, pc_4, stall, halt_req, resume,
        input  pc, fetch_valid, flush, halted, retired_cnt, taken_cnt, jump_cnt
    );
endinterface

// File: rtl/pc_sequencer_sat_counter.sv
// pc_sequencer_sat_counter: W-bit up counter that sticks at all-ones
module pc_sequencer_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else if (inc && !(&cnt)) cnt <= cnt + 1'b1;
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: architectural PC register, BOOT/RUN/HALT control, redirect flush and retire statistics
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = PCS_RESET_PC,
    parameter int          CNT_W    = 32
) (
    input logic             clk,
    input logic             rst_n,
    pc_sequencer_if.master  bus
);
    pcs_state_e  state, state_nxt;
    logic [31:0] pc_q, pc_nxt;
    logic        flush_q, flush_nxt;
    logic        inc_ret, inc_tkn, inc_jmp;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state   <= PCS_BOOT;
            pc_q    <= RESET_PC;
            flush_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            pc_q    <= pc_nxt;
            flush_q <= flush_nxt;
        end
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_q;
        flush_nxt = 1'b0;
        inc_ret   = 1'b0;
        inc_tkn   = 1'b0;
        inc_jmp   = 1'b0;
        if (state == PCS_BOOT)
            state_nxt = PCS_RUN;
        else if (state == PCS_HALT)
            state_nxt = bus.resume ? PCS_RUN : PCS_HALT;
        else if (state != PCS_RUN)
            state_nxt = PCS_BOOT;
        else if (bus.halt_req) begin
            // the halting instruction retires; resume continues after it
            state_nxt = PCS_HALT;
            pc_nxt    = bus.pc_4;
            inc_ret   = 1'b1;
        end else if (!bus.stall) begin
            pc_nxt    = bus.pc_new;
            inc_ret   = 1'b1;
            inc_tkn   = bus.branched;
            inc_jmp   = bus.is_jump;
            flush_nxt = bus.branched | bus.is_jump;
        end
    end
    assign bus.pc          = pc_q;
    assign bus.flush       = flush_q;
    assign bus.fetch_valid = state == PCS_RUN;
    assign bus.halted      = state == PCS_HALT;
    pc_sequencer_sat_counter #(.W(CNT_W)) u_retired (.clk(clk), .rst_n(rst_n), .inc(inc_ret), .cnt(bus.retired_cnt));
    pc_sequencer_sat_counter #(.W(CNT_W)) u_taken   (.clk(clk), .rst_n(rst_n), .inc(inc_tkn), .cnt(bus.taken_cnt));
    pc_sequencer_sat_counter #(.W(CNT_W)) u_jump    (.clk(clk), .rst_n(rst_n), .inc(inc_jmp), .cnt(bus.jump_cnt));
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: table-driven vectors plus async-reset and saturation sequences for pc_sequencer
module tb_pc_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rst4_n = 1'b0;
    always #5 clk = ~clk;
    pc_sequencer_if #(.CNT_W(32)) bus();
    pc_sequencer_if #(.CNT_W(4))  b4();
    pc_sequencer #(.RESET_PC(32'h0), .CNT_W(32)) dut  (.clk(clk), .rst_n(rst_n),  .bus(bus));
    pc_sequencer #(.RESET_PC(32'h0), .CNT_W(4))  dut4 (.clk(clk), .rst_n(rst4_n), .bus(b4));
    int checks = 0;
    int failures = 0;
    typedef struct {
        logic        stall, halt_req, branched, is_jump, resume;
        logic [31:0] pc_new, pc_4, e_pc;
        logic        e_fv, e_flush, e_halted;
        logic [31:0] e_ret, e_tkn, e_jmp;
    } vec_t;
    vec_t v[22];
    function automatic vec_t mk(input logic s, h, b, j, r, input logic [31:0] pn, p4, epc,
                                input logic fv, fl, hl, input logic [31:0] er, et, ej);
        vec_t x;
        x.stall = s; x.halt_req = h; x.branched = b; x.is_jump = j; x.resume = r;
        x.pc_new = pn; x.pc_4 = p4; x.e_pc = epc;
        x.e_fv = fv; x.e_flush = fl; x.e_halted = hl;
        x.e_ret = er; x.e_tkn = et; x.e_jmp = ej;
        return x;
    endfunction
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic check_all(input string tag, input logic [31:0] epc, input logic fv, fl, hl,
                             input logic [31:0] er, et, ej);
        check({tag, ".pc"}, bus.pc, epc);
        check({tag, ".fetch_valid"}, {31'b0, bus.fetch_valid}, {31'b0, fv});
        check({tag, ".flush"}, {31'b0, bus.flush}, {31'b0, fl});
        check({tag, ".halted"}, {31'b0, bus.halted}, {31'b0, hl});
        check({tag, ".retired"}, bus.retired_cnt, er);
        check({tag, ".taken"}, bus.taken_cnt, et);
        check({tag, ".jump"}, bus.jump_cnt, ej);
    endtask
    task automatic drive(input logic s, h, b, j, r, input logic [31:0] pn, p4);
        bus.stall = s; bus.halt_req = h; bus.branched = b; bus.is_jump = j; bus.resume = r;
        bus.pc_new = pn; bus.pc_4 = p4;
    endtask
    initial begin
        drive(0, 0, 0, 0, 0, 32'h0, 32'h0);
        b4.stall = 0; b4.halt_req = 0; b4.branched = 1; b4.is_jump = 1; b4.resume = 0;
        b4.pc_new = 32'h4; b4.pc_4 = 32'h0;
        v[0]  = mk(0, 0, 0, 0, 0, 32'h4,    32'h0,  32'h0,   1, 0, 0, 0,  0, 0);
        v[1]  = mk(0, 0, 0, 0, 0, 32'h4,    32'h0,  32'h4,   1, 0, 0, 1,  0, 0);
        v[2]  = mk(0, 0, 0, 0, 0, 32'h8,    32'h0,  32'h8,   1, 0, 0, 2,  0, 0);
        v[3]  = mk(0, 0, 1, 0, 0, 32'h40,   32'h0,  32'h40,  1, 1, 0, 3,  1, 0);
        v[4]  = mk(0, 0, 0, 0, 0, 32'h44,   32'h0,  32'h44,  1, 0, 0, 4,  1, 0);
        v[5]  = mk(0, 0, 0, 1, 0, 32'h100,  32'h0,  32'h100, 1, 1, 0, 5,  1, 1);
        v[6]  = mk(0, 0, 1, 0, 0, 32'h200,  32'h0,  32'h200, 1, 1, 0, 6,  2, 1);
        v[7]  = mk(0, 0, 0, 0, 0, 32'h204,  32'h0,  32'h204, 1, 0, 0, 7,  2, 1);
        for (int i = 8; i <= 10; i++)
            v[i] = mk(1, 0, 1, 0, 0, 32'h80, 32'h0, 32'h204, 1, 0, 0, 7, 2, 1);
        v[11] = mk(0, 0, 1, 0, 0, 32'h80,   32'h0,  32'h80,  1, 1, 0, 8,  3, 1);
        v[12] = mk(0, 0, 0, 0, 0, 32'h20,   32'h0,  32'h20,  1, 0, 0, 9,  3, 1);
        v[13] = mk(1, 1, 1, 0, 0, 32'h999,  32'h24, 32'h24,  0, 0, 1, 10, 3, 1);
        for (int i = 14; i <= 18; i++)
            v[i] = mk(1, 1, 1, 1, 0, 32'hdead, 32'h0, 32'h24, 0, 0, 1, 10, 3, 1);
        v[19] = mk(0, 0, 0, 0, 1, 32'h0,    32'h0,  32'h24,  1, 0, 0, 10, 3, 1);
        v[20] = mk(1, 0, 0, 0, 1, 32'h0,    32'h0,  32'h24,  1, 0, 0, 10, 3, 1);
        v[21] = mk(0, 0, 0, 0, 0, 32'h28,   32'h0,  32'h28,  1, 0, 0, 11, 3, 1);
        #12;
        check_all("reset", 32'h0, 0, 0, 0, 0, 0, 0);
        #11 rst_n = 1'b1;
        #1 check_all("boot", 32'h0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 22; i++) begin
            drive(v[i].stall, v[i].halt_req, v[i].branched, v[i].is_jump, v[i].resume, v[i].pc_new, v[i].pc_4);
            @(posedge clk);
            #1 check_all($sformatf("vec%0d", i), v[i].e_pc, v[i].e_fv, v[i].e_flush, v[i].e_halted,
                         v[i].e_ret, v[i].e_tkn, v[i].e_jmp);
        end
        // async reset while a flush pulse is showing
        drive(0, 0, 0, 1, 0, 32'h300, 32'h0);
        @(posedge clk);
        #1 check_all("preflush", 32'h300, 1, 1, 0, 12, 3, 2);
        #2 rst_n = 1'b0;
        #1 check_all("rst_flush", 32'h0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 32'h0, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1 check_all("reboot", 32'h0, 1, 0, 0, 0, 0, 0);
        // async reset while halted
        drive(0, 1, 0, 0, 0, 32'h0, 32'h50);
        @(posedge clk);
        #1 check_all("prehalt", 32'h50, 0, 0, 1, 1, 0, 0);
        #2 rst_n = 1'b0;
        #1 check_all("rst_halt", 32'h0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 32'h0, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        // 4-bit counters saturate at 4'hF
        @(negedge clk) rst4_n = 1'b1;
        @(posedge clk);
        #1 check("sat.boot_ret", {28'b0, b4.retired_cnt}, 32'h0);
        repeat (14) @(posedge clk);
        #1 check("sat.ret14", {28'b0, b4.retired_cnt}, 32'hE);
        repeat (6) @(posedge clk);
        #1;
        check("sat.ret20", {28'b0, b4.retired_cnt}, 32'hF);
        check("sat.tkn20", {28'b0, b4.taken_cnt}, 32'hF);
        check("sat.jmp20", {28'b0, b4.jump_cnt}, 32'hF);
        check("sat.flush", {31'b0, b4.flush}, 32'h1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the architectural PC register and sequences the where-to-go unit.
- Each cycle, the where-to-go unit's pc_new/branched result for the current PC is either committed, held (stall) or replaced by halt handling.
- Generates a one-cycle flush pulse after any control-flow redirect.
- Keeps saturating statistics counters (retired, taken branches, jumps) for the display/debug path.
- Sits between the decoder/where-to-go unit and the instruction fetch port.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
CNT_W, 32, width of each statistics counter

Ports:
clk  in  1  core clock, all state updates on rising edge
rst_n  in  1  reset, asynchronous assert, active-low
pc_new  in  32  next PC from where-to-go unit for current pc
branched  in  1  conditional branch taken for current instruction
is_jump  in  1  current instruction is J26/J32-class jump (from decoder)
pc_4  in  32  current pc + 4 (from fetch adder)
stall  in  1  hold current instruction this cycle
halt_req  in  1  current instruction is a halt (syscall-halt)
resume  in  1  leave HALT (debug button, already synchronised)
pc  out  32  current PC, drives fetch address
fetch_valid  out  1  pc holds a valid instruction to execute
flush  out  1  registered one-cycle pulse after a redirect
halted  out  1  high in HALT state
retired_cnt  out  CNT_W  instructions retired
taken_cnt  out  CNT_W  conditional branches taken
jump_cnt  out  CNT_W  unconditional jumps executed

Behaviour:
- Reset (rst_n low, async): state BOOT, pc=RESET_PC, flush=0, all counters 0; combinational outputs follow state (fetch_valid=0, halted=0).
- States:
  - BOOT: always goes to RUN next cycle; pc unchanged.
  - RUN: fetch_valid=1.
  - HALT: halted=1, fetch_valid=0.
- In RUN, evaluated once per cycle, in priority order:
  1. halt_req=1 (stall and branched ignored): pc<=pc_4; retired_cnt+1; state->HALT; no flush.
  2. stall=1: pc, counters, state held; flush<=0.
  3. Otherwise "step":
     - pc<=pc_new; retired_cnt+1.
     - taken_cnt+1 if branched; jump_cnt+1 if is_jump.
     - flush<=1 if (branched|is_jump), else 0.
- flush is cleared every cycle not covered by rule 3; max width one cycle, even for back-to-back redirects (each redirect step produces its own pulse).
- HALT: resume=1 -> RUN next cycle, pc unchanged (already pc_4 of halting instruction); resume=0 -> stay. resume outside HALT is ignored.
- Counters saturate at all-ones; no wrap.
- pc_new is committed verbatim: no alignment check or masking; width 32 throughout.
- Latency: one cycle from step to new pc on the output; flush is visible in the same cycle as the new pc.
- Reset mid-operation: immediate return to reset values regardless of state; a pending flush is dropped.
- Inputs are don't-care in BOOT and HALT, except resume in HALT.

Decomposition:
- Shared core package/header:
  - state encoding constants PCS_BOOT, PCS_RUN, PCS_HALT (2-bit, PCS_STATE_BIT=2)
  - RESET_PC default macro
- Natural sub-module: sat_counter (parameter W; inputs clk, rst_n, inc; output cnt).
  - Instantiated three times for retired/taken/jump.
- FSM and pc register stay in pc_sequencer.

Test Plan:
- Reset release, then 3 cycles with pc_new=pc+4, no branch -> pc 0x0 (BOOT), 0x0, 0x4, 0x8; fetch_valid 0 then 1; retired_cnt 2; flush never high.
- At pc=0x8, branched=1, pc_new=0x40 -> next cycle pc=0x40, flush=1 for exactly one cycle, taken_cnt=1.
- Back-to-back redirects: J to 0x100 then branch to 0x200 on consecutive cycles -> jump_cnt=1, taken_cnt+1, flush high both following cycles.
- stall=1 for 3 cycles with branched=1, pc_new=0x80 -> pc frozen, counters unchanged, flush 0; on stall release, pc=0x80 and one flush pulse.
- halt_req=1 with branched=1 at pc=0x20 (pc_4=0x24) -> HALT, pc=0x24, halted=1, fetch_valid=0, no flush.
  - 5 idle cycles -> unchanged.
  - resume pulse -> RUN next cycle with pc=0x24.
- CNT_W=4: 20 steps -> retired_cnt holds 4'hF.
- rst_n asserted mid-HALT and mid-flush pulse -> outputs return to reset values asynchronously, before the next clock edge.
